// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable width, parity and stop bits,
// 3-sample majority voting per bit, per-frame parity/framing/break status.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int IDX_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(H + 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_err(input logic [DATA_BITS-1:0] data,
                                      input logic                 pbit);
    logic ones_odd;
    ones_odd = (^data) ^ pbit;
    if (PARITY == 1) return ~ones_odd;
    if (PARITY == 2) return ones_odd;
    return 1'b0;
  endfunction

  // Control state (reset)
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 rx_meta_q, rx_sync_q;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;

  // Datapath state (no reset; always rewritten before use)
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic                 par_q, par_d;
  logic                 stop0_q, stop0_d;
  logic                 ferr_acc_q, ferr_acc_d;

  logic vote, at_s2, bit_end, timed, first_stop, brk_det;

  assign vote       = maj3(s0_q, s1_q, rx_sync_q);
  assign at_s2      = (cnt_q == CNT_S2);
  assign bit_end    = (cnt_q == CNT_LAST);
  assign timed      = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
  assign first_stop = (idx_q == '0) ? vote : stop0_q;
  assign brk_det    = (shift_q == '0) && ((PARITY == 0) || !par_q) && !first_stop;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    shift_d    = shift_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    par_d      = par_q;
    stop0_d    = stop0_q;
    ferr_acc_d = ferr_acc_q;

    if (timed) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_S0) s0_d = rx_sync_q;
      if (cnt_q == CNT_S1) s1_d = rx_sync_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_sync_q) begin
          state_d    = S_START;
          ferr_acc_d = 1'b0;
        end
      end
      S_START: begin
        if (at_s2 && vote) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (at_s2) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (at_s2) par_d = vote;
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (at_s2) begin
          if (idx_q == '0) stop0_d = vote;
          ferr_acc_d = ferr_acc_q | ~vote;
          // Leave mid-bit after the last stop sample so a back-to-back
          // start edge is not missed.
          if (idx_q == STOP_LAST) begin
            dv_d    = 1'b1;
            byte_d  = shift_q;
            perr_d  = parity_err(shift_q, par_q);
            ferr_d  = ferr_acc_q | ~vote;
            brk_d   = brk_det;
            state_d = brk_det ? S_BREAK_WAIT : S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        if (bit_end && (idx_q != STOP_LAST)) idx_d = idx_q + IDX_W'(1);
      end
      S_BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      dv_q      <= 1'b0;
      byte_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
      dv_q      <= dv_d;
      byte_q    <= byte_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    shift_q    <= shift_d;
    s0_q       <= s0_d;
    s1_q       <= s1_d;
    par_q      <= par_d;
    stop0_q    <= stop0_d;
    ferr_acc_q <= ferr_acc_d;
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Break      = brk_q;
  // Held through the strobe cycle so busy drops the cycle after o_Rx_DV.
  assign o_Busy       = (state_q != S_IDLE) || dv_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and randomized bench for uart_rx_frame (16 clk/bit, 8E1),
// checked against a frame-level reference model.
module tb_uart_rx_frame;
  localparam int C   = 16;
  localparam int DB  = 8;
  localparam int PAR = 2;
  localparam int SB  = 1;
  localparam int N   = 1 + DB + 1 + SB;
  localparam int H   = C / 2;
  // Input fall -> first START cycle is 3 clocks; strobe at (N-1)*C+H+2 after.
  localparam int STROBE_LAT = 3 + (N - 1) * C + H + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv, pe, fe, br, busy;
  logic [7:0] byte_o;

  uart_rx_frame #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (DB),
    .PARITY      (PAR),
    .STOP_BITS   (SB)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_Serial (rx),
    .o_Rx_DV     (dv),
    .o_Rx_Byte   (byte_o),
    .o_Parity_Err(pe),
    .o_Frame_Err (fe),
    .o_Break     (br),
    .o_Busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    logic       pe;
    logic       fe;
    logic       br;
  } strobe_t;

  strobe_t sq[$];

  always @(negedge clk) begin
    strobe_t s;
    if (dv) begin
      s.cyc = cyc;
      s.b   = byte_o;
      s.pe  = pe;
      s.fe  = fe;
      s.br  = br;
      sq.push_back(s);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what a correct receiver reports for one wire frame.
  function automatic strobe_t model(input logic [7:0] d, input logic p, input logic s,
                                    input int fall);
    strobe_t m;
    m.cyc = fall + STROBE_LAT;
    m.b   = d;
    m.pe  = (^d) ^ p;
    m.fe  = !s;
    m.br  = (d == 8'h00) && !p && !s;
    return m;
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_wire(input logic [10:0] fr, input int glitch, input int ncyc,
                           output int fall);
    fall = cyc;
    for (int w = 0; w < ncyc; w++) begin
      rx = fr[w / C] ^ (w == glitch);
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic check_strobe(input string tag, input logic [7:0] d, input logic p,
                              input logic s, input int fall, output int got_cyc);
    strobe_t e, g;
    e = model(d, p, s, fall);
    got_cyc = -1;
    chk({tag, " strobe count"}, sq.size(), 1);
    if (sq.size() != 0) begin
      g = sq.pop_front();
      got_cyc = g.cyc;
      chk({tag, " byte"},      g.b,   e.b);
      chk({tag, " parity_err"}, g.pe, e.pe);
      chk({tag, " frame_err"}, g.fe,  e.fe);
      chk({tag, " break"},     g.br,  e.br);
      chk({tag, " strobe cycle"}, g.cyc, e.cyc);
    end
    sq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " dv"},    dv,     1'b0);
    chk({tag, " byte"},  byte_o, 8'h00);
    chk({tag, " pe"},    pe,     1'b0);
    chk({tag, " fe"},    fe,     1'b0);
    chk({tag, " br"},    br,     1'b0);
    chk({tag, " busy"},  busy,   1'b0);
  endtask

  initial begin
    int fall, c1, c2, gc;
    logic [7:0] d;
    logic p, s;

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(5);

    // Clean frame
    send_wire(mk(8'hA5, 1'b0, 1'b1), -1, N * C, fall);
    check_strobe("a5", 8'hA5, 1'b0, 1'b1, fall, gc);
    chk("a5 busy after frame", busy, 1'b0);
    wait_clks(5);

    // Wrong parity
    send_wire(mk(8'h3C, 1'b1, 1'b1), -1, N * C, fall);
    check_strobe("3c parity", 8'h3C, 1'b1, 1'b1, fall, gc);
    wait_clks(5);

    // Stop bit low
    send_wire(mk(8'h81, 1'b0, 1'b0), -1, N * C, fall);
    check_strobe("81 framing", 8'h81, 1'b0, 1'b0, fall, gc);
    wait_clks(2 * C);
    chk("81 no extra strobe", sq.size(), 0);

    // Break: line low 20 bit times
    fall = cyc;
    rx = 1'b0;
    wait_clks(20 * C);
    check_strobe("break", 8'h00, 1'b0, 1'b0, fall, gc);
    chk("break busy while low", busy, 1'b1);
    rx = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("break busy rel+1", busy, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("break busy rel+2", busy, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("break busy rel+3", busy, 1'b0);
    wait_clks(2 * C);
    chk("break single strobe", sq.size(), 0);

    // False start: 3-clock low pulse
    rx = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("false start busy before start", busy, 1'b0);
    @(posedge clk); #1;
    rx = 1'b1;
    @(negedge clk);
    chk("false start busy rises", busy, 1'b1);
    wait_clks(2 * C);
    chk("false start busy cleared", busy, 1'b0);
    chk("false start no strobe", sq.size(), 0);

    // One-clock high glitch at count H of data bit 2
    send_wire(mk(8'h00, 1'b0, 1'b1), 3 * C + H + 1, N * C, fall);
    check_strobe("glitch", 8'h00, 1'b0, 1'b1, fall, gc);
    wait_clks(5);

    // Back-to-back frames
    send_wire(mk(8'h55, 1'b0, 1'b1), -1, N * C, fall);
    check_strobe("b2b first", 8'h55, 1'b0, 1'b1, fall, c1);
    send_wire(mk(8'hAA, 1'b0, 1'b1), -1, N * C, fall);
    check_strobe("b2b second", 8'hAA, 1'b0, 1'b1, fall, c2);
    chk("b2b spacing", c2 - c1, N * C);

    // Reset during bit 4 of a third frame
    send_wire(mk(8'h5A, 1'b0, 1'b1), -1, 4 * C + H, fall);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("mid-frame reset");
    rst = 1'b0;
    rx  = 1'b1;
    wait_clks(N * C);
    chk("mid-frame reset no strobe", sq.size(), 0);
    chk("mid-frame reset idle", busy, 1'b0);

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      send_wire(mk(d, p, s), -1, N * C, fall);
      check_strobe("random", d, p, s, fall, gc);
      if (s) wait_clks($urandom_range(0, 4));
      else   wait_clks(2 * C);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, expected finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver that succeeds the fixed 8N1 receiver. Adds configurable data width, optional odd/even parity, one or two stop bits, 3-sample majority voting, and per-frame parity, framing and break status. Sits between the board RX pin and the packet-parsing logic. Delivers one received word per single-cycle strobe.

## Interface
- CLKS_PER_BIT, 434: clock cycles per bit (i_Clock frequency / baud); legal range >= 4.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

- i_Clock  in  1  system clock; the block's only clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line; idles high.
- o_Rx_DV  out  1  one-cycle strobe; a frame completed.
- o_Rx_Byte  out  DATA_BITS  received data, LSB first on the wire; held until the next o_Rx_DV.
- o_Parity_Err  out  1  parity mismatch on the last frame; always 0 when PARITY = 0.
- o_Frame_Err  out  1  at least one stop bit sampled 0 on the last frame.
- o_Break  out  1  the last frame was a break condition.
- o_Busy  out  1  high whenever the state is not IDLE.

## Operation
- Input synchroniser: i_Rx_Serial passes through two flops, both reset to 1. All decisions use the second flop.
- States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- Frame length: N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- Bit counter: runs 0..CLKS_PER_BIT-1 per bit, width $clog2(CLKS_PER_BIT).
- Sample points: let H = CLKS_PER_BIT/2 (integer). Each bit is sampled at counts H-1, H and H+1; the bit value is the majority of the three samples.
- IDLE -> START: when the synchronised line reads 0. The counter is 0 in the first START cycle.
- START:
  - majority 1 at count H+1 is a false start: go to IDLE, no strobe.
  - majority 0: continue timing and enter DATA at the end of the bit period.
- DATA: shifts in DATA_BITS bits LSB first. Goes to PARITY if enabled, otherwise STOP.
- PARITY: checks the received parity bit against the data.
  - odd: data plus parity bit has an odd number of 1s.
  - even: data plus parity bit has an even number of 1s.
- STOP: each stop bit is sampled by majority; any 0 sets the frame error. After the final stop bit's count-H+1 sample:
  - o_Rx_DV pulses for one cycle.
  - o_Rx_Byte, o_Parity_Err, o_Frame_Err and o_Break are updated in the same cycle.
  - State goes to IDLE without finishing the bit period, so a back-to-back start edge is caught.
- Break: data all 0, parity bit 0 (if present) and first stop bit 0.
  - Reported as o_Break = 1 and o_Frame_Err = 1, with o_Rx_Byte = 0.
  - State then goes to BREAK_WAIT until the synchronised line reads 1, then IDLE.
  - Exactly one strobe per break, however long the line stays low.
- Status outputs are registered with the data and held until the next strobe.
- Reset mid-frame: the frame is aborted and no strobe is issued.

## Timing
- Reset values:
  - o_Rx_DV, o_Parity_Err, o_Frame_Err, o_Break and o_Busy are 0.
  - o_Rx_Byte is 0.
  - State is IDLE, counters are 0, synchroniser flops are 1.
- Start detection: the first START cycle is 3 clocks after i_Rx_Serial falls (2 synchroniser clocks plus the state register).
- Frame timing: take cycle 0 as the first START cycle. Bit k (start bit = 0) occupies cycles k*C .. k*C+C-1, where C = CLKS_PER_BIT.
- Strobe: o_Rx_DV is high in exactly cycle (N-1)*C + H + 2.
- o_Busy: rises in cycle 0. It falls in the cycle after o_Rx_DV, or after BREAK_WAIT exits, or after a false start is rejected.
- Back-to-back frames with no idle gap are received with no lost frames.

## Test plan
All scenarios use CLKS_PER_BIT = 16, DATA_BITS = 8, PARITY = 2 (even), STOP_BITS = 1, so N = 11 and H = 8.
- Send 0xA5 with correct parity bit 0 -> single o_Rx_DV at cycle 170 after START entry; o_Rx_Byte = 0xA5; all error flags 0.
- Send 0x3C with parity bit 1 -> o_Rx_Byte = 0x3C, o_Parity_Err = 1, o_Frame_Err = 0.
- Send 0x81 with correct parity and stop bit 0 -> o_Frame_Err = 1, o_Break = 0, o_Rx_Byte = 0x81.
- Hold the line low for 20 bit times, then release:
  - exactly one o_Rx_DV, with o_Rx_Byte = 0x00, o_Break = 1 and o_Frame_Err = 1;
  - o_Busy stays 1 until 3 cycles after release, then 0.
- Glitch handling:
  - a 3-clock low pulse on an idle line -> no o_Rx_DV, o_Busy returns to 0;
  - a 1-clock high glitch at count H of data bit 2 while sending 0x00 -> o_Rx_Byte = 0x00, no errors.
- Back-to-back and reset:
  - 0x55 then 0xAA with no gap -> two strobes 176 cycles apart with the correct bytes;
  - i_Reset asserted during bit 4 of a third frame -> no strobe, all outputs return to their reset values next cycle.
